// File: rtl/mine_pkg.sv
// Shared types and constants for the Minesweeper sequencing controller.
package mine_pkg;

   localparam int N_CELLS_DEF = 25;
   localparam int CELL_W = 5;

   typedef enum logic [3:0] {
      IDLE,
      PLACE,
      WAIT_GUESS,
      LOAD,
      DECODE,
      ALU,
      CHECK,
      OVER,
      ERR
   } mine_ctrl_state_t;

   typedef struct packed {
      logic mine;
      logic win;
   } move_res_t;

endpackage

// File: rtl/mine_ctrl_wdog.sv
// Per-command watchdog counter for mine_ctrl (used with MINE_CTRL_TIMEOUT_EN).
module mine_ctrl_wdog #(
   parameter int LIMIT = 16
) (
   input  logic clka,
   input  logic restart,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clka) begin
      if (restart || clr)
         cnt <= '0;
      else if (en && cnt != W'(LIMIT))
         cnt <= cnt + 1'b1;
   end

   // cnt is 0 on the first cycle in a state, so this fires on cycle LIMIT
   assign expired = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/mine_ctrl.sv
// Minesweeper guess sequencer; optional watchdog under MINE_CTRL_TIMEOUT_EN.
module mine_ctrl
   import mine_pkg::*;
#(
   parameter int N_CELLS        = N_CELLS_DEF,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clka,
   input  logic              restart,
   input  logic              new_game,
   input  logic              guess_valid,
   input  logic [CELL_W-1:0] guess,
   output logic              guess_ready,
   output logic              start,
   output logic              load,
   output logic              decode,
   output logic              alu,
   output logic [CELL_W-1:0] data,
   input  logic              place_done,
   input  logic              decode_done,
   input  logic              alu_done,
   input  logic              gameover,
   input  logic              win,
   output logic              bad_guess,
   output logic              move_valid,
   output logic              move_mine,
   output logic              move_win,
   output logic [CELL_W-1:0] move_count,
   output logic              err
);

   mine_ctrl_state_t state, state_nx;

   logic      first_q;
   logic      cmd_done;
   logic      qual;
   logic      guess_ok;
   logic      accept;
   logic      reject;
   logic      expired;
   move_res_t res_q;
   move_res_t res_now;

   always_comb begin
      cmd_done = 1'b0;
      unique case (state)
         PLACE:   cmd_done = place_done;
         DECODE:  cmd_done = decode_done;
         ALU:     cmd_done = alu_done;
         default: cmd_done = 1'b0;
      endcase
   end

   // Level done flags may be left over from the last command
   assign qual = cmd_done & ~first_q;

   assign guess_ok = {1'b0, guess} < (CELL_W + 1)'(N_CELLS);
   assign accept   = (state == WAIT_GUESS) & guess_valid & guess_ok;
   assign reject   = (state == WAIT_GUESS) & guess_valid & ~guess_ok;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:       if (new_game) state_nx = PLACE;
         PLACE:      if (qual) state_nx = WAIT_GUESS;
                     else if (expired) state_nx = ERR;
         WAIT_GUESS: if (accept) state_nx = LOAD;
         LOAD:       state_nx = DECODE;
         DECODE:     if (qual) state_nx = ALU;
                     else if (expired) state_nx = ERR;
         ALU:        if (qual) state_nx = CHECK;
                     else if (expired) state_nx = ERR;
         CHECK:      state_nx = gameover ? OVER : WAIT_GUESS;
         OVER:       if (new_game) state_nx = PLACE;
         ERR:        state_nx = ERR;
         default:    state_nx = IDLE;
      endcase
   end

`ifdef MINE_CTRL_TIMEOUT_EN
   logic wd_en;
   logic wd_clr;

   assign wd_en  = state inside {PLACE, DECODE, ALU};
   assign wd_clr = state_nx != state;

   mine_ctrl_wdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wdog (
      .clka    (clka),
      .restart (restart),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (expired)
   );

   always_ff @(posedge clka) begin
      if (restart)
         err <= 1'b0;
      else if (expired && !qual)
         err <= 1'b1;
   end
`else
   assign expired = 1'b0;
   assign err     = 1'b0;
`endif

   always_ff @(posedge clka) begin
      if (restart) begin
         state      <= IDLE;
         first_q    <= 1'b1;
         data       <= '0;
         move_count <= '0;
         res_q      <= '0;
      end else begin
         state   <= state_nx;
         first_q <= state_nx != state;
         if (accept) begin
            data <= guess;
            if (move_count != '1)
               move_count <= move_count + 1'b1;
         end
         if (state == PLACE && qual)
            move_count <= '0;
         if (state == CHECK)
            res_q <= res_now;
      end
   end

   always_comb begin
      res_now.mine = gameover & ~win;
      res_now.win  = win;
   end

   assign guess_ready = state == WAIT_GUESS;
   assign start       = state == PLACE;
   assign load        = state == LOAD;
   assign decode      = state == DECODE;
   assign alu         = state == ALU;
   assign bad_guess   = reject;
   assign move_valid  = state == CHECK;
   assign move_mine   = move_valid ? res_now.mine : res_q.mine;
   assign move_win    = move_valid ? res_now.win : res_q.win;

endmodule

// File: tb/tb_mine_ctrl.sv
// Self-checking bench for mine_ctrl; watchdog steps run with MINE_CTRL_TIMEOUT_EN.
module tb_mine_ctrl;

   logic       clka = 1'b0;
   logic       restart;
   logic       new_game;
   logic       guess_valid;
   logic [4:0] guess;
   logic       guess_ready;
   logic       start;
   logic       load;
   logic       decode;
   logic       alu;
   logic [4:0] data;
   logic       place_done;
   logic       decode_done;
   logic       alu_done;
   logic       gameover;
   logic       win;
   logic       bad_guess;
   logic       move_valid;
   logic       move_mine;
   logic       move_win;
   logic [4:0] move_count;
   logic       err;

   int total = 0;
   int bad = 0;
   int exp_cnt = 0;
   bit in_over = 0;

   always #5 clka = ~clka;

   mine_ctrl dut (
      .clka        (clka),
      .restart     (restart),
      .new_game    (new_game),
      .guess_valid (guess_valid),
      .guess       (guess),
      .guess_ready (guess_ready),
      .start       (start),
      .load        (load),
      .decode      (decode),
      .alu         (alu),
      .data        (data),
      .place_done  (place_done),
      .decode_done (decode_done),
      .alu_done    (alu_done),
      .gameover    (gameover),
      .win         (win),
      .bad_guess   (bad_guess),
      .move_valid  (move_valid),
      .move_mine   (move_mine),
      .move_win    (move_win),
      .move_count  (move_count),
      .err         (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic cmd_of(input int w);
      case (w)
         0:       return start;
         1:       return decode;
         default: return alu;
      endcase
   endfunction

   // Responder: raise done dly cycles after command start; count cycles high
   task automatic run_cmd(input int which, input int dly, input int limit,
                          output int cycles);
      cycles = 0;
      for (int k = 0; k < limit; k++) begin
         if (k > 0) @(negedge clka);
         case (which)
            0:       place_done = (k >= dly);
            1:       decode_done = (k >= dly);
            default: alu_done = (k >= dly);
         endcase
         #1;
         if (cmd_of(which) !== 1'b1) break;
         cycles++;
         chk("onehot", 32'($countones({start, load, decode, alu}) <= 1), 1);
      end
   endtask

   function automatic int hold_len(input int dly);
      return (dly < 1 ? 1 : dly) + 1;
   endfunction

   task automatic do_restart();
      @(negedge clka);
      restart = 1; new_game = 0; guess_valid = 0;
      place_done = 0; decode_done = 0; alu_done = 0;
      @(negedge clka);
      restart = 0;
      #1;
      chk("rst_outs", {guess_ready, start, load, decode, alu, data,
                       bad_guess, move_valid, move_mine, move_win,
                       move_count}, 0);
      chk("rst_err", err, 0);
      exp_cnt = 0;
      in_over = 0;
   endtask

   task automatic do_place(input int dly);
      int c;
      @(negedge clka);
      new_game = 1;
      #1;
      chk("start_pre", start, 0);
      @(negedge clka);
      new_game = 0;
      run_cmd(0, dly, 40, c);
      chk("place_cycles", c, hold_len(dly));
      chk("rdy_placed", guess_ready, 1);
      chk("start_drop", start, 0);
      chk("cnt_clear", move_count, 0);
      exp_cnt = 0;
      in_over = 0;
   endtask

   task automatic do_guess(input logic [4:0] g, input logic go,
                           input logic wn, input int dd, input int ad,
                           input logic ng);
      int c;
      @(negedge clka);
      guess_valid = 1; guess = g; new_game = ng;
      gameover = go; win = wn;
      #1;
      chk("rdy_accept", guess_ready, 1);
      chk("bad_accept", bad_guess, 0);
      @(negedge clka);
      guess_valid = 0; new_game = 0; guess = 5'($urandom);
      #1;
      exp_cnt = (exp_cnt < 31) ? exp_cnt + 1 : 31;
      chk("load", load, 1);
      chk("data", data, g);
      chk("cnt", move_count, exp_cnt);
      chk("rdy_load", guess_ready, 0);
      @(negedge clka);
      run_cmd(1, dd, 40, c);
      chk("dec_cycles", c, hold_len(dd));
      chk("data_hold", data, g);
      run_cmd(2, ad, 40, c);
      chk("alu_cycles", c, hold_len(ad));
      chk("mv_valid", move_valid, 1);
      chk("mv_mine", move_mine, go & ~wn);
      chk("mv_win", move_win, wn);
      chk("cmds_check", {start, load, decode, alu}, 0);
      chk("data_check", data, g);
      @(negedge clka);
      gameover = 1'($urandom); win = 1'($urandom);
      #1;
      chk("mv_pulse", move_valid, 0);
      chk("mine_hold", move_mine, go & ~wn);
      chk("win_hold", move_win, wn);
      chk("rdy_after", guess_ready, !go);
      in_over = go;
   endtask

   task automatic do_bad(input logic [4:0] g);
      @(negedge clka);
      guess_valid = 1; guess = g;
      #1;
      chk("bad_pulse", bad_guess, 1);
      chk("bad_rdy", guess_ready, 1);
      @(negedge clka);
      guess_valid = 0;
      #1;
      chk("bad_once", bad_guess, 0);
      chk("bad_noload", load, 0);
      chk("bad_rdy2", guess_ready, 1);
      chk("bad_cnt", move_count, exp_cnt);
   endtask

   initial begin
      int c;
      logic go;
      restart = 1; new_game = 0; guess_valid = 0; guess = 0;
      place_done = 0; decode_done = 0; alu_done = 0;
      gameover = 0; win = 0;
      repeat (2) @(posedge clka);

      do_restart();
      do_place(1);
      do_guess(5'd3, 0, 0, 1, 1, 0);
      do_bad(5'd27);
      do_guess(5'd10, 0, 0, 0, 0, 0);
      do_guess(5'd5, 0, 0, 2, 3, 1);

      @(negedge clka);
      new_game = 1;
      @(negedge clka);
      new_game = 0;
      #1;
      chk("ng_ignored", start, 0);
      chk("ng_rdy", guess_ready, 1);

      for (int i = 0; i < 45; i++) begin
         if ($urandom_range(0, 4) == 0)
            do_bad(5'(25 + $urandom_range(0, 6)));
         else
            do_guess(5'($urandom_range(0, 24)), 0, 0,
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)));
      end
      chk("cnt_sat", move_count, 31);

      do_guess(5'd17, 1, 0, 1, 1, 0);
      @(negedge clka);
      guess_valid = 1; guess = 5'd2;
      @(negedge clka);
      guess_valid = 0;
      #1;
      chk("over_noload", load, 0);
      chk("over_rdy", guess_ready, 0);
      chk("over_mine", move_mine, 1);
      do_place(2);

      for (int i = 0; i < 25; i++) begin
         if (in_over) do_place($urandom_range(0, 3));
         go = ($urandom_range(0, 5) == 0);
         do_guess(5'($urandom_range(0, 24)), go,
                  go & 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 3), 0);
      end
      if (in_over) do_place(1);
      do_guess(5'd8, 1, 1, 1, 2, 0);
      do_place(0);
      do_guess(5'd24, 0, 0, 1, 1, 0);

      @(negedge clka);
      guess_valid = 1; guess = 5'd12;
      @(negedge clka);
      guess_valid = 0; decode_done = 0;
      @(negedge clka);
      restart = 1;
      #1;
      chk("mid_decode", decode, 1);
      @(negedge clka);
      restart = 0;
      #1;
      chk("mid_cmds", {start, load, decode, alu}, 0);
      chk("mid_mv", move_valid, 0);
      chk("mid_rdy", guess_ready, 0);
      chk("mid_cnt", move_count, 0);
      repeat (3) begin
         @(negedge clka);
         #1;
         chk("mid_quiet", {move_valid, start, load, decode, alu}, 0);
      end
      do_place(1);

`ifdef MINE_CTRL_TIMEOUT_EN
      @(negedge clka);
      guess_valid = 1; guess = 5'd4;
      @(negedge clka);
      guess_valid = 0;
      @(negedge clka);
      run_cmd(1, 1, 40, c);
      chk("to_dec", c, 2);
      run_cmd(2, 1000, 40, c);
      chk("to_alu_cycles", c, 16);
      chk("to_err", err, 1);
      chk("to_alu_low", alu, 0);
      new_game = 1;
      repeat (3) @(negedge clka);
      new_game = 0;
      #1;
      chk("err_sticky", err, 1);
      chk("err_cmds", {start, load, decode, alu, guess_ready}, 0);
      do_restart();
`else
      chk("no_err", err, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
